interrupt_result_checker: RTL and testbench
===========================================

Name: interrupt_result_checker

Overview:
- Synthesizable on-chip counterpart to the CPU's debug/interrupt port. The CPU raises `interrupt` when a test checkpoint is reached; this block responds by sampling the debug register read-back and comparing it against a programmed table of expected values.
- Aggregates results into pass/fail/done status with a watchdog, so FPGA runs can self-check without a simulator.
- Sits beside `cpu`: drives `regAddr` and `memAddr`, consumes `regTest` and `interrupt`.

Parameters:
- `NUM_TESTS`, 12, number of expected-value entries; also the checkpoint count that completes a run.
- `IDX_W`, 4, width of the table index; must satisfy 2^IDX_W >= NUM_TESTS.
- `WATCH_REG`, 25, register address driven on `regAddr` (t9).
- `WATCH_MEM`, 100, word address driven on `memAddr`.
- `TIMEOUT`, 4096, maximum cycles allowed between checkpoints before a timeout is declared.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that arms a run (IDLE->RUN).
- `cfg_we` in 1: expected-table write enable.
- `cfg_addr` in IDX_W: expected-table write index.
- `cfg_data` in 32: expected-table write data.
- `interrupt` in 1: CPU checkpoint flag, synchronous to `clk`.
- `regTest` in 32: CPU register read-back data.
- `regAddr` out 5: constant WATCH_REG.
- `memAddr` out 14: constant WATCH_MEM.
- `test_idx` out IDX_W: index of the next checkpoint to be checked.
- `done` out 1: run complete.
- `passed` out 1: valid when `done`; 1 = all checkpoints matched.
- `fail_idx` out IDX_W: index of the first mismatch.
- `fail_got` out 32: `regTest` value captured at the first mismatch.
- `timeout` out 1: watchdog expired.
- `extra_irq` out 1: an interrupt edge arrived after the run completed.

Behaviour:
- Reset values: `test_idx`=0, `done`=0, `passed`=0, `fail_idx`=0, `fail_got`=0, `timeout`=0, `extra_irq`=0, `irq_q`=0, watchdog=0, state=IDLE. The expected table is not reset.
- Edge detect: `irq_q` registers `interrupt`. A checkpoint event is `interrupt & ~irq_q`. `regTest` is sampled in that same cycle, with zero added latency; the comparison result is registered on that clock edge.
- Table writes are accepted in every state, are visible on the next cycle, and take effect for all later compares. Writes with `cfg_addr` >= NUM_TESTS are ignored.
- States and transitions:
  - IDLE: events are ignored. `start` clears `test_idx`, `fail_*`, `timeout`, `extra_irq`, `done`, `passed` and the watchdog, sets the internal `ok` flag to 1, and enters RUN.
  - RUN, on an event: compare `regTest` with `table[test_idx]`.
    - On mismatch with `ok`=1: latch `fail_idx` and `fail_got`, then clear `ok`. Later mismatches do not overwrite `fail_*`.
    - Then increment `test_idx`.
    - If `test_idx` == NUM_TESTS-1: go to DONE, set `done`=1, set `passed` = `ok` AND this compare's result.
  - RUN, watchdog: increments every cycle without an event and clears on an event. On reaching TIMEOUT: set `timeout`=1, `done`=1, `passed`=0, go to DONE.
  - DONE: outputs hold. Any further event sets `extra_irq`=1 (sticky) and leaves `passed` unchanged. `start` re-arms exactly as from IDLE.
- Simultaneous events:
  - `start` together with an event: `start` wins and the event is dropped.
  - An event in the same cycle the watchdog expires: the event wins and the timeout is not declared.
  - `interrupt` held high for multiple cycles counts once; it must drop and rise again to produce another event.
- Reset mid-run: returns immediately to IDLE with all outputs at their reset values.
- `test_idx` never exceeds NUM_TESTS-1 while in RUN and never wraps.

Test Plan:
- Load {15,20,25,30,35,40,45,9,27,3,1,0}, pulse `start`, apply 12 interrupt pulses with matching `regTest` -> `done`=1, `passed`=1, `test_idx`=11, `timeout`=0, `extra_irq`=0.
- Same table, but event 4 presents 36 and event 9 presents 7 -> `done`=1, `passed`=0, `fail_idx`=4, `fail_got`=36 (the second mismatch does not overwrite).
- Hold `interrupt` high for 5 cycles with `regTest`=15, then proceed normally -> only one checkpoint consumed; `test_idx` is 1 after the first pulse.
- After 3 valid events, stop pulsing for TIMEOUT cycles -> `timeout`=1, `done`=1, `passed`=0, `test_idx`=3. A 13th pulse after a passing run -> `extra_irq`=1, `passed` stays 1.
- Assert `rst_n`=0 asynchronously mid-run at `test_idx`=6 -> all outputs return to 0 immediately, with no clock edge required. Then `start` plus 12 good events -> `passed`=1.
- `start` coincident with an interrupt edge -> the event is ignored and `test_idx`=0. `cfg_we` to index 15 -> no table change.

Source files
------------

// File: rtl/interrupt_result_checker.sv
// Checkpoint result checker: on each rising interrupt edge, compares the debug
// register read-back against a programmed table and aggregates pass/fail/timeout status.
module interrupt_result_checker #(
    parameter int NUM_TESTS = 12,
    parameter int IDX_W     = 4,
    parameter int WATCH_REG = 25,
    parameter int WATCH_MEM = 100,
    parameter int TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [31:0]      cfg_data,
    input  logic             interrupt,
    input  logic [31:0]      regTest,
    output logic [4:0]       regAddr,
    output logic [13:0]      memAddr,
    output logic [IDX_W-1:0] test_idx,
    output logic             done,
    output logic             passed,
    output logic [IDX_W-1:0] fail_idx,
    output logic [31:0]      fail_got,
    output logic             timeout,
    output logic             extra_irq
);

    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TESTS - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic             ok_q, ok_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [IDX_W-1:0] test_idx_q, test_idx_d;
    logic             done_q, done_d;
    logic             passed_q, passed_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [31:0]      fail_got_q, fail_got_d;
    logic             timeout_q, timeout_d;
    logic             extra_irq_q, extra_irq_d;

    logic [31:0]      table_q [NUM_TESTS];
    logic             irq_event;
    logic             match;

    // NOTE: the expected table is plain storage with no reset, so it can map to RAM
    // and survives a reset between runs.
    always_ff @(posedge clk) begin
        if (cfg_we && (cfg_addr <= LAST_IDX)) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    assign irq_event = interrupt & ~irq_q;
    assign match     = (regTest == table_q[test_idx_q]);

    // NOTE: every variable gets its hold value first so no path through the case
    // statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        irq_d       = interrupt;
        ok_d        = ok_q;
        wd_d        = wd_q;
        test_idx_d  = test_idx_q;
        done_d      = done_q;
        passed_d    = passed_q;
        fail_idx_d  = fail_idx_q;
        fail_got_d  = fail_got_q;
        timeout_d   = timeout_q;
        extra_irq_d = extra_irq_q;

        if (start) begin
            // Arming takes priority over any coincident checkpoint, which is dropped.
            state_d     = S_RUN;
            ok_d        = 1'b1;
            wd_d        = '0;
            test_idx_d  = '0;
            done_d      = 1'b0;
            passed_d    = 1'b0;
            fail_idx_d  = '0;
            fail_got_d  = '0;
            timeout_d   = 1'b0;
            extra_irq_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (irq_event) begin
                        wd_d = '0;
                        if (!match) begin
                            ok_d = 1'b0;
                            if (ok_q) begin
                                fail_idx_d = test_idx_q;
                                fail_got_d = regTest;
                            end
                        end
                        if (test_idx_q == LAST_IDX) begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            passed_d = ok_q & match;
                        end else begin
                            test_idx_d = test_idx_q + 1'b1;
                        end
                    end else begin
                        wd_d = wd_q + 1'b1;
                        if (wd_q == WD_LAST) begin
                            state_d   = S_DONE;
                            timeout_d = 1'b1;
                            done_d    = 1'b1;
                            passed_d  = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (irq_event) begin
                        extra_irq_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from the values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            irq_q       <= 1'b0;
            ok_q        <= 1'b0;
            wd_q        <= '0;
            test_idx_q  <= '0;
            done_q      <= 1'b0;
            passed_q    <= 1'b0;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
            timeout_q   <= 1'b0;
            extra_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            ok_q        <= ok_d;
            wd_q        <= wd_d;
            test_idx_q  <= test_idx_d;
            done_q      <= done_d;
            passed_q    <= passed_d;
            fail_idx_q  <= fail_idx_d;
            fail_got_q  <= fail_got_d;
            timeout_q   <= timeout_d;
            extra_irq_q <= extra_irq_d;
        end
    end

    assign regAddr   = 5'(WATCH_REG);
    assign memAddr   = 14'(WATCH_MEM);
    assign test_idx  = test_idx_q;
    assign done      = done_q;
    assign passed    = passed_q;
    assign fail_idx  = fail_idx_q;
    assign fail_got  = fail_got_q;
    assign timeout   = timeout_q;
    assign extra_irq = extra_irq_q;

endmodule

// File: tb/tb_interrupt_result_checker.sv
// Self-checking bench for interrupt_result_checker: directed scenarios plus
// randomized runs scored against a table/sequence reference model.
module tb_interrupt_result_checker;

    localparam int NUM_TESTS = 12;
    localparam int IDX_W     = 4;
    localparam int TIMEOUT   = 4096;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_addr = '0;
    logic [31:0]      cfg_data = '0;
    logic             interrupt = 1'b0;
    logic [31:0]      regTest = '0;
    logic [4:0]       regAddr;
    logic [13:0]      memAddr;
    logic [IDX_W-1:0] test_idx;
    logic             done;
    logic             passed;
    logic [IDX_W-1:0] fail_idx;
    logic [31:0]      fail_got;
    logic             timeout;
    logic             extra_irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: expected table as the bench believes it, and the values to present.
    logic [31:0] exp_tab [NUM_TESTS];
    logic [31:0] present [NUM_TESTS];

    interrupt_result_checker #(
        .NUM_TESTS(NUM_TESTS), .IDX_W(IDX_W), .WATCH_REG(25), .WATCH_MEM(100), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .interrupt(interrupt), .regTest(regTest), .regAddr(regAddr),
        .memAddr(memAddr), .test_idx(test_idx), .done(done), .passed(passed),
        .fail_idx(fail_idx), .fail_got(fail_got), .timeout(timeout), .extra_irq(extra_irq)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_addr = IDX_W'(addr);
        cfg_data = data;
        step();
        cfg_we = 1'b0;
        if (addr < NUM_TESTS) exp_tab[addr] = data;
    endtask

    task automatic load_plan_table();
        int vals [NUM_TESTS] = '{15, 20, 25, 30, 35, 40, 45, 9, 27, 3, 1, 0};
        for (int i = 0; i < NUM_TESTS; i++) cfg_write(i, 32'(vals[i]));
        for (int i = 0; i < NUM_TESTS; i++) present[i] = exp_tab[i];
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] val, input int hold, input int gap);
        interrupt = 1'b1;
        regTest   = val;
        repeat (hold) step();
        interrupt = 1'b0;
        regTest   = $urandom;
        repeat (gap) step();
    endtask

    // Arms a run, presents all checkpoints and scores the outcome against the model.
    task automatic run_and_compare(input string name, input int max_hold, input int max_gap);
        logic        m_pass;
        int          m_fidx;
        logic [31:0] m_fgot;
        int          e_idx;
        m_pass = 1'b1;
        m_fidx = 0;
        m_fgot = '0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            if (m_pass && present[i] !== exp_tab[i]) begin
                m_pass = 1'b0;
                m_fidx = i;
                m_fgot = present[i];
            end
        end
        arm();
        for (int i = 0; i < NUM_TESTS; i++) begin
            pulse(present[i], $urandom_range(max_hold, 1), $urandom_range(max_gap, 1));
            e_idx = (i < NUM_TESTS - 1) ? i + 1 : NUM_TESTS - 1;
            n_cmp++;
            if (test_idx !== IDX_W'(e_idx) || done !== (i == NUM_TESTS - 1)) begin
                n_err++;
                $display("FAIL %s progress ev%0d: test_idx=%0d done=%b, required test_idx=%0d done=%b",
                         name, i, test_idx, done, e_idx, (i == NUM_TESTS - 1));
            end
        end
        n_cmp++;
        if (passed !== m_pass || timeout !== 1'b0 || extra_irq !== 1'b0) begin
            n_err++;
            $display("FAIL %s status: passed=%b timeout=%b extra_irq=%b, required %b 0 0",
                     name, passed, timeout, extra_irq, m_pass);
        end
        n_cmp++;
        if (fail_idx !== IDX_W'(m_fidx) || fail_got !== m_fgot) begin
            n_err++;
            $display("FAIL %s fail_info: fail_idx=%0d fail_got=%0d, required %0d %0d",
                     name, fail_idx, fail_got, m_fidx, m_fgot);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_cmp++;
        if ({test_idx, done, passed, fail_idx, fail_got, timeout, extra_irq} !== '0) begin
            n_err++;
            $display("FAIL reset_state: outputs=%h, required 0",
                     {test_idx, done, passed, fail_idx, fail_got, timeout, extra_irq});
        end
        n_cmp++;
        if (regAddr !== 5'd25 || memAddr !== 14'd100) begin
            n_err++;
            $display("FAIL watch_addr: regAddr=%0d memAddr=%0d, required 25 100", regAddr, memAddr);
        end
        rst_n = 1'b1;
        step();
        pulse(32'd15, 1, 1);
        n_cmp++;
        if (test_idx !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores_event: test_idx=%0d done=%b, required 0 0", test_idx, done);
        end
    endtask

    task automatic test_all_pass();
        load_plan_table();
        run_and_compare("all_pass", 1, 1);
    endtask

    task automatic test_extra_irq();
        pulse(32'd99, 1, 1);
        n_cmp++;
        if (extra_irq !== 1'b1 || passed !== 1'b1 || test_idx !== IDX_W'(NUM_TESTS - 1)) begin
            n_err++;
            $display("FAIL extra_irq: extra_irq=%b passed=%b test_idx=%0d, required 1 1 11",
                     extra_irq, passed, test_idx);
        end
    endtask

    task automatic test_mismatch();
        present[4] = 32'd36;
        present[9] = 32'd7;
        run_and_compare("mismatch", 1, 2);
        present[4] = exp_tab[4];
        present[9] = exp_tab[9];
    endtask

    task automatic test_hold();
        arm();
        pulse(32'd15, 5, 1);
        n_cmp++;
        if (test_idx !== 1) begin
            n_err++;
            $display("FAIL hold_counts_once: test_idx=%0d, required 1", test_idx);
        end
        for (int i = 1; i < NUM_TESTS; i++) pulse(present[i], 1, 1);
        n_cmp++;
        if (done !== 1'b1 || passed !== 1'b1) begin
            n_err++;
            $display("FAIL hold_run: done=%b passed=%b, required 1 1", done, passed);
        end
    endtask

    task automatic test_timeout();
        arm();
        for (int i = 0; i < 3; i++) pulse(present[i], 1, 1);
        repeat (TIMEOUT - 8) step();
        n_cmp++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: timeout=%b done=%b, required 0 0", timeout, done);
        end
        repeat (16) step();
        n_cmp++;
        if (timeout !== 1'b1 || done !== 1'b1 || passed !== 1'b0 || test_idx !== 3) begin
            n_err++;
            $display("FAIL timeout: timeout=%b done=%b passed=%b test_idx=%0d, required 1 1 0 3",
                     timeout, done, passed, test_idx);
        end
    endtask

    task automatic test_start_coincident();
        start     = 1'b1;
        interrupt = 1'b1;
        regTest   = 32'hBAD0_BAD0;
        step();
        start     = 1'b0;
        interrupt = 1'b0;
        step();
        n_cmp++;
        if (test_idx !== '0 || done !== 1'b0 || timeout !== 1'b0 || fail_got !== '0) begin
            n_err++;
            $display("FAIL start_wins: test_idx=%0d done=%b timeout=%b fail_got=%0h, required 0 0 0 0",
                     test_idx, done, timeout, fail_got);
        end
        for (int i = 0; i < NUM_TESTS; i++) pulse(present[i], 1, 1);
        n_cmp++;
        if (done !== 1'b1 || passed !== 1'b1) begin
            n_err++;
            $display("FAIL start_wins_run: done=%b passed=%b, required 1 1", done, passed);
        end
    endtask

    task automatic test_cfg_ignore();
        cfg_write(15, 32'hDEAD_BEEF);
        cfg_write(12, 32'hCAFE_F00D);
        run_and_compare("cfg_ignore", 1, 1);
    endtask

    task automatic test_async_reset();
        arm();
        present[2] = 32'd1234;
        for (int i = 0; i < 6; i++) pulse(present[i], 1, 1);
        present[2] = exp_tab[2];
        n_cmp++;
        if (test_idx !== 6 || fail_got !== 32'd1234) begin
            n_err++;
            $display("FAIL pre_reset: test_idx=%0d fail_got=%0d, required 6 1234", test_idx, fail_got);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({test_idx, done, passed, fail_idx, fail_got, timeout, extra_irq} !== '0) begin
            n_err++;
            $display("FAIL async_reset: outputs=%h, required 0",
                     {test_idx, done, passed, fail_idx, fail_got, timeout, extra_irq});
        end
        step();
        rst_n = 1'b1;
        step();
        run_and_compare("after_reset", 1, 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(4, 0)) cfg_write($urandom_range(15, 0), $urandom);
            if (r == 0) for (int i = 0; i < NUM_TESTS; i++) cfg_write(i, $urandom);
            for (int i = 0; i < NUM_TESTS; i++)
                present[i] = ($urandom_range(7, 0) == 0) ? $urandom : exp_tab[i];
            run_and_compare("random", 3, 3);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_extra_irq();
        test_mismatch();
        test_hold();
        test_timeout();
        test_start_coincident();
        test_cfg_ignore();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
